sync_r2w_status: RTL and testbench
==================================

# sync_r2w_status

Parametrised read-pointer synchroniser with write-side status for the asynchronous FIFO. It moves the Gray-coded read pointer into the write clock domain through a configurable-depth flop chain and converts it to binary in a registered stage. It then produces fill level, full and almost-full flags against the local write pointer, plus a synchroniser-ready indication. It sits in the write domain between the read-pointer logic and the write-control/full logic, and supersedes the fixed two-flop read-to-write synchroniser.

## Interface
- ADDRSIZE, 4, FIFO address width; pointers are ADDRSIZE+1 bits (extra wrap bit)
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4
- AFULL_THRESH, 2**ADDRSIZE-2, fill level at or above which walmost_full asserts
- wclk  input  1  write-domain clock; all state on rising edge
- wrst  input  1  asynchronous, active-high reset
- rptr  input  ADDRSIZE+1  Gray-coded read pointer from read domain
- wbin  input  ADDRSIZE+1  binary write pointer, write domain
- wq_rptr  output  ADDRSIZE+1  synchronised Gray read pointer (last chain stage)
- wq_rbin  output  ADDRSIZE+1  registered binary of wq_rptr
- wlevel  output  ADDRSIZE+1  (wbin - wq_rbin) mod 2**(ADDRSIZE+1)
- wfull  output  1  FIFO full, write side
- walmost_full  output  1  wlevel >= AFULL_THRESH
- sync_valid  output  1  chain flushed since reset
- gray_err  output  1  sticky: synchronised pointer changed by more than one bit

## Operation
- Reset (wrst=1, asynchronous): every chain stage, wq_rptr, wq_rbin, previous-sample register, ready counter, gray_err and sync_valid go to 0. wfull=1 and walmost_full=1, forced while sync_valid=0. wlevel is combinational from wbin and wq_rbin, so it equals wbin during reset.
- Chain: stage0 samples rptr; stage i samples stage i-1; wq_rptr = stage SYNC_STAGES-1.
- Binary stage: wq_rbin <= gray2bin(wq_rptr) each edge.
- Level: wlevel = wbin - wq_rbin, unsigned, truncated to ADDRSIZE+1 bits; wrap-around is handled by the modulo.
- Full: wlevel == 2**ADDRSIZE, i.e. MSBs differ and the lower ADDRSIZE bits are equal; OR-ed with !sync_valid.
- Almost full: (wlevel >= AFULL_THRESH) OR !sync_valid.
- Ready counter: saturating, counts edges after reset release. sync_valid=1 once the count reaches SYNC_STAGES+1 and stays 1 until the next reset.
- Gray check: the previous wq_rptr is registered. When sync_valid=1 and popcount(wq_rptr ^ prev) > 1, gray_err is set. It is cleared only by wrst.
- Reset mid-operation: asynchronous clear regardless of chain contents. Flags are forced to 1 until re-flush, so no write is accepted on a stale pointer.

## Timing
- rptr stable before edge k: wq_rptr updates after edge k+SYNC_STAGES-1, and wq_rbin after edge k+SYNC_STAGES. Total latency is SYNC_STAGES+1 edges to the binary value and flags.
- wlevel, wfull and walmost_full are combinational from wbin and registered state, so a wbin change is reflected in the same cycle.
- gray_err asserts after the edge following the offending wq_rptr update.
- sync_valid rises after the (SYNC_STAGES+1)th rising edge following wrst deassertion.

## Configuration
- SYNC_R2W_GRAYCHK_EN defined: the previous-sample register, popcount compare and sticky gray_err are compiled in.
- Not defined: that logic is absent and gray_err is tied to 0. All other behaviour is identical.

## Structure
- Package sync_pkg holds:
  - function gray2bin(ADDRSIZE+1 bits);
  - function onehot_or_zero for the single-bit-change check;
  - constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4 (elaboration assertion on the range).
- Sub-module sync_stage_chain: a WIDTH x SYNC_STAGES flop array with asynchronous active-high clear, reused later for the write-to-read direction.

## Test plan
- Reset release, ADDRSIZE=4, SYNC_STAGES=2:
  - sync_valid=0 with wfull=walmost_full=1 for 2 edges;
  - sync_valid=1 after the 3rd edge;
  - wfull=0 with wbin=0.
- Latency: rptr 5'b00000 -> 5'b00001 before edge k -> wq_rptr=00001 after edge k+1, wq_rbin=1 after edge k+2.
- Full: wbin=5'b10000, rptr=0 synced -> wlevel=16, wfull=1, walmost_full=1; wbin=5'b01110 -> wlevel=14, wfull=0, walmost_full=1.
- Wrap: wbin=5'b00010, rptr Gray 5'b10000 (binary 31) synced -> wlevel=3, wfull=0, walmost_full=0.
- Gray error: rptr 5'b00000 -> 5'b00011 -> gray_err=1 one edge after wq_rptr shows 00011, held through further traffic, cleared by wrst. Without SYNC_R2W_GRAYCHK_EN, gray_err stays 0.
- Mid-operation reset: pulse wrst between edges with chain non-zero -> all registered outputs are 0 immediately, wfull=1, sync_valid=0, and re-flush takes 3 edges.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared helpers for the FIFO pointer synchronisers: Gray decode, single-bit
// change check and legal synchroniser depth range.
package sync_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Widest pointer the helpers accept; narrower pointers are zero-extended,
    // which leaves both the Gray decode and the change check unaffected.
    localparam int unsigned PTR_MAX_W = 32;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // True when at most one bit of the XOR difference vector is set.
    function automatic logic onehot_or_zero(input logic [PTR_MAX_W-1:0] diff);
        return (diff & (diff - PTR_MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// Generic WIDTH x STAGES synchroniser flop chain with asynchronous
// active-high clear. Used for both pointer-crossing directions.
module sync_stage_chain
    import sync_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_stage_chain: STAGES out of range");
    end

    logic [STAGES-1:0][WIDTH-1:0] stage;

    // Shift the sampled value one stage deeper every edge; stage 0 takes d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_r2w_status.sv
// Read-to-write pointer synchroniser with write-side fill level, full,
// almost-full, synchroniser-ready and optional Gray-integrity status.
// Optional feature macro: SYNC_R2W_GRAYCHK_EN (sticky gray_err checker).
module sync_r2w_status
    import sync_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic [ADDRSIZE:0] rptr,
    input  logic [ADDRSIZE:0] wbin,
    output logic [ADDRSIZE:0] wq_rptr,
    output logic [ADDRSIZE:0] wq_rbin,
    output logic [ADDRSIZE:0] wlevel,
    output logic              wfull,
    output logic              walmost_full,
    output logic              sync_valid,
    output logic              gray_err
);

    localparam int unsigned PW = ADDRSIZE + 1;
    localparam int unsigned CW = $clog2(SYNC_STAGES_MAX + 2);
    localparam logic [CW-1:0] CNT_DONE   = CW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_ARM    = CW'(SYNC_STAGES);
    localparam logic [PW-1:0] FULL_LEVEL = PW'(1 << ADDRSIZE);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_r2w_status: SYNC_STAGES out of range");
    end
    if (PW > PTR_MAX_W) begin : g_bad_addrsize
        $error("sync_r2w_status: ADDRSIZE too large");
    end

    logic [CW-1:0] ready_cnt;

    sync_stage_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_chain (
        .clk (wclk),
        .rst (wrst),
        .d   (rptr),
        .q   (wq_rptr)
    );

    // Decode the synchronised Gray pointer into a registered binary copy.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wq_rbin <= '0;
        end else begin
            wq_rbin <= PW'(gray2bin(PTR_MAX_W'(wq_rptr)));
        end
    end

    // Count edges since reset release; ready once the chain and decoder have flushed.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            ready_cnt  <= '0;
            sync_valid <= 1'b0;
        end else begin
            if (ready_cnt != CNT_DONE) begin
                ready_cnt <= ready_cnt + CW'(1);
            end
            if (ready_cnt >= CNT_ARM) begin
                sync_valid <= 1'b1;
            end
        end
    end

`ifdef SYNC_R2W_GRAYCHK_EN
    logic [PW-1:0] prev_rptr;

    // Flag any multi-bit jump of the synchronised pointer; sticky until reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            prev_rptr <= '0;
            gray_err  <= 1'b0;
        end else begin
            prev_rptr <= wq_rptr;
            if (sync_valid && !onehot_or_zero(PTR_MAX_W'(wq_rptr ^ prev_rptr))) begin
                gray_err <= 1'b1;
            end
        end
    end
`else
    assign gray_err = 1'b0;
`endif

    // Write-side status; flags held asserted until the synchroniser is ready.
    always_comb begin
        wlevel       = wbin - wq_rbin;
        wfull        = !sync_valid || (wlevel == FULL_LEVEL);
        walmost_full = !sync_valid || (32'(wlevel) >= AFULL_THRESH);
    end

endmodule

// File: tb/tb_sync_r2w_status.sv
// Scoreboard bench for sync_r2w_status (ADDRSIZE=4, SYNC_STAGES=2).
module tb_sync_r2w_status;

    localparam int unsigned ADDRSIZE = 4;
    localparam int unsigned S        = 2;
    localparam int unsigned THRESH   = 14;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic [4:0] rptr = '0;
    logic [4:0] wbin = '0;
    logic [4:0] wq_rptr, wq_rbin, wlevel;
    logic       wfull, walmost_full, sync_valid, gray_err;

    sync_r2w_status #(
        .ADDRSIZE     (ADDRSIZE),
        .SYNC_STAGES  (S),
        .AFULL_THRESH (THRESH)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .rptr         (rptr),
        .wbin         (wbin),
        .wq_rptr      (wq_rptr),
        .wq_rbin      (wq_rbin),
        .wlevel       (wlevel),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .sync_valid   (sync_valid),
        .gray_err     (gray_err)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [4:0] wq_rptr;
        logic [4:0] wq_rbin;
        logic [4:0] wlevel;
        logic       wfull;
        logic       walmost_full;
        logic       sync_valid;
        logic       gray_err;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         bin_of_gray[32];
    logic [4:0] hist[$];
    int         edges    = 0;
    bit         gerr_m   = 1'b0;
`ifdef SYNC_R2W_GRAYCHK_EN
    bit         chk_en   = 1'b1;
`else
    bit         chk_en   = 1'b0;
`endif

    // Reference: value seen on wq_rptr after edge m is the rptr sampled S-1 edges earlier.
    function automatic logic [4:0] exp_wq(input int m);
        int idx;
        idx = m - int'(S);
        if (idx < 0) return 5'd0;
        return hist[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: build expectations on every clock edge or reset assertion.
    initial begin
        exp_t e;
        logic [4:0] rb;
        for (int b = 0; b < 32; b++) bin_of_gray[b ^ (b >> 1)] = b;
        #1;
        forever begin
            @(posedge wclk or posedge wrst);
            if (wrst) begin
                hist.delete();
                edges  = 0;
                gerr_m = 1'b0;
            end else begin
                hist.push_back(rptr);
                edges++;
                if (chk_en && (edges - 1 >= int'(S) + 1) &&
                    $countones(exp_wq(edges - 1) ^ exp_wq(edges - 2)) > 1)
                    gerr_m = 1'b1;
            end
            rb             = 5'(bin_of_gray[exp_wq(edges - 1)]);
            e.sync_valid   = (edges >= int'(S) + 1);
            e.wq_rptr      = exp_wq(edges);
            e.wq_rbin      = rb;
            e.wlevel       = 5'((int'(wbin) - int'(rb) + 32) % 32);
            e.wfull        = !e.sync_valid || (e.wlevel == 5'd16);
            e.walmost_full = !e.sync_valid || (int'(e.wlevel) >= int'(THRESH));
            e.gray_err     = gerr_m;
            sb.push_back(e);
        end
    end

    // Monitor: compare DUT outputs shortly after each edge against the oldest expectation.
    initial begin
        exp_t e;
        #1;
        forever begin
            @(posedge wclk or posedge wrst);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = sb.pop_front();
                chk("wq_rptr",      32'(wq_rptr),      32'(e.wq_rptr));
                chk("wq_rbin",      32'(wq_rbin),      32'(e.wq_rbin));
                chk("wlevel",       32'(wlevel),       32'(e.wlevel));
                chk("wfull",        32'(wfull),        32'(e.wfull));
                chk("walmost_full", 32'(walmost_full), 32'(e.walmost_full));
                chk("sync_valid",   32'(sync_valid),   32'(e.sync_valid));
                chk("gray_err",     32'(gray_err),     32'(e.gray_err));
            end
        end
    end

    // Stimulus: inputs change on the falling edge only.
    initial begin
        logic [4:0] rb;
        wrst = 1'b1;
        rptr = '0;
        wbin = '0;
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        repeat (6) @(negedge wclk);

        // latency of a single-bit pointer step
        rptr = 5'b00001;
        repeat (5) @(negedge wclk);

        // exactly full, then almost full
        rptr = 5'b00000;
        wbin = 5'b10000;
        repeat (5) @(negedge wclk);
        wbin = 5'b01110;
        repeat (2) @(negedge wclk);

        // wrap-around level
        rptr = 5'b10000;
        wbin = 5'b00010;
        repeat (5) @(negedge wclk);

        // legal Gray traffic with random write pointer
        rb = 5'd31;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) rb = rb + 5'd1;
            rptr = rb ^ (rb >> 1);
            if ($urandom_range(0, 3) == 0) wbin = 5'($urandom);
            else                           wbin = rb + 5'($urandom_range(0, 16));
            @(negedge wclk);
        end

        // two-bit jump on the read pointer
        rptr = rptr ^ 5'b00011;
        repeat (5) @(negedge wclk);
        for (int i = 0; i < 100; i++) begin
            rptr = 5'($urandom);
            wbin = 5'($urandom);
            @(negedge wclk);
        end

        // asynchronous reset between edges with a non-zero chain
        rptr = 5'b00101;
        wbin = 5'b00111;
        repeat (4) @(negedge wclk);
        #1 wrst = 1'b1;
        #2 wrst = 1'b0;
        repeat (6) @(negedge wclk);

        // legal traffic after re-flush
        rb = 5'(bin_of_gray[rptr]);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) rb = rb + 5'd1;
            rptr = rb ^ (rb >> 1);
            wbin = rb + 5'($urandom_range(0, 17));
            @(negedge wclk);
        end
        repeat (2) @(negedge wclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
